// File: rtl/zluudg_bee_pkg.sv
// Shared types, constants and the CRC-16/KERMIT octet step for the zluudgbee PHY.
package zluudg_bee_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PHR,
        ST_PAYLOAD
    } state_t;

    localparam logic [7:0]  SFD_DEFAULT   = 8'hA7;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
    localparam int          MAX_PSDU      = 127;

    // Reflected CRC: the octet enters LSB first, so eight shift-right steps unroll into one cycle.
    function automatic logic [15:0] crc16_kermit_byte(input logic [15:0] crc, input logic [7:0] octet);
        logic [15:0] c;
        c = crc ^ {8'h00, octet};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/zluudg_crc16_kermit.sv
// Combinational CRC-16/KERMIT step over one octet; shared by the RX and TX paths.
module zluudg_crc16_kermit
    import zluudg_bee_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  octet,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_kermit_byte(crc_in, octet);

endmodule

// File: rtl/zluudg_psdu_deframer.sv
// Finds the 802.15.4 SHR in the demodulated octet stream, reads the PHR length and
// forwards the PSDU as one AXI-stream packet with FCS status on the last beat.
module zluudg_psdu_deframer
    import zluudg_bee_pkg::*;
#(
    parameter int         PREAMBLE_MIN = 2,
    parameter logic [7:0] SFD          = SFD_DEFAULT,
    parameter int         MIN_LEN      = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_octet_tdata,
    input  logic        s_octet_tvalid,
    output logic        s_octet_tready,
    input  logic        s_octet_tlast,
    output logic [31:0] m_psdu_tdata,
    output logic        m_psdu_tvalid,
    input  logic        m_psdu_tready,
    output logic        m_psdu_tlast,
    output logic [1:0]  m_psdu_tuser,
    output logic [15:0] frame_count,
    output logic [15:0] crc_err_count
);

    state_t      state_q, state_d;
    logic [3:0]  zcnt_q, zcnt_d;
    logic [6:0]  remaining_q, remaining_d;
    logic [15:0] crc_q, crc_d, crc_next;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [1:0]  user_q, user_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] crc_err_q, crc_err_d;

    logic [7:0]  octet;
    logic        out_free;
    logic        accept;
    logic        unused_tdata;

    assign octet        = s_octet_tdata[7:0];
    assign unused_tdata = ^s_octet_tdata[31:8];
    assign out_free     = !valid_q || m_psdu_tready;

    // Only PAYLOAD needs the output register; the SHR can be consumed while a beat is stalled.
    assign s_octet_tready = (state_q == ST_PAYLOAD) ? out_free : 1'b1;
    assign accept         = s_octet_tvalid && s_octet_tready;

    zluudg_crc16_kermit u_crc (
        .crc_in  (crc_q),
        .octet   (octet),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d     = state_q;
        zcnt_d      = zcnt_q;
        remaining_d = remaining_q;
        crc_d       = crc_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        user_d      = user_q;
        frame_cnt_d = frame_cnt_q;
        crc_err_d   = crc_err_q;

        if (valid_q && m_psdu_tready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            user_d  = 2'b00;
        end

        case (state_q)
            ST_HUNT: begin
                if (accept) begin
                    if (s_octet_tlast) begin
                        zcnt_d = 4'd0;
                    end else if (octet == 8'h00) begin
                        zcnt_d = (zcnt_q == 4'hF) ? zcnt_q : zcnt_q + 4'd1;
                    end else if (octet == SFD && 32'(zcnt_q) >= PREAMBLE_MIN) begin
                        zcnt_d  = 4'd0;
                        state_d = ST_PHR;
                    end else begin
                        zcnt_d = 4'd0;
                    end
                end
            end

            ST_PHR: begin
                if (accept) begin
                    if (s_octet_tlast || 32'(octet[6:0]) < MIN_LEN) begin
                        state_d = ST_HUNT;
                    end else begin
                        remaining_d = octet[6:0];
                        crc_d       = 16'h0000;
                        state_d     = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
                    crc_d       = crc_next;
                    remaining_d = remaining_q - 7'd1;
                    valid_d     = 1'b1;
                    data_d      = octet;
                    last_d      = 1'b0;
                    user_d      = 2'b00;
                    // The final octet wins over a coincident burst end: the frame is complete.
                    if (remaining_q == 7'd1) begin
                        last_d      = 1'b1;
                        user_d      = {1'b0, crc_next == 16'h0000};
                        state_d     = ST_HUNT;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (crc_next != 16'h0000) begin
                            crc_err_d = crc_err_q + 16'd1;
                        end
                    end else if (s_octet_tlast) begin
                        last_d      = 1'b1;
                        user_d      = 2'b10;
                        state_d     = ST_HUNT;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        crc_err_d   = crc_err_q + 16'd1;
                    end
                end
            end

            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_HUNT;
            zcnt_q      <= 4'd0;
            remaining_q <= 7'd0;
            crc_q       <= 16'h0000;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            user_q      <= 2'b00;
            frame_cnt_q <= 16'd0;
            crc_err_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            zcnt_q      <= zcnt_d;
            remaining_q <= remaining_d;
            crc_q       <= crc_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            user_q      <= user_d;
            frame_cnt_q <= frame_cnt_d;
            crc_err_q   <= crc_err_d;
        end
    end

    assign m_psdu_tdata  = {24'h000000, data_q};
    assign m_psdu_tvalid = valid_q;
    assign m_psdu_tlast  = last_q;
    assign m_psdu_tuser  = user_q;
    assign frame_count   = frame_cnt_q;
    assign crc_err_count = crc_err_q;

endmodule

// File: tb/tb_zluudg_psdu_deframer.sv
// Directed self-checking bench for zluudg_psdu_deframer and its CRC step.
module tb_zluudg_psdu_deframer;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] sTdata;
   logic        sTvalid;
   logic        sTready;
   logic        sTlast;
   logic [31:0] mTdata;
   logic        mTvalid;
   logic        mTready;
   logic        mTlast;
   logic [1:0]  mTuser;
   logic [15:0] frameCount;
   logic [15:0] crcErrCount;

   logic [15:0] katIn;
   logic [7:0]  katOctet;
   logic [15:0] katOut;

   int checkCount = 0;
   int errorCount = 0;
   int readyMode = 0;

   logic [8:0]  stimQ[$];
   logic [10:0] outQ[$];
   logic [10:0] expQ[$];
   logic [10:0] heldBeat;
   logic        heldValid = 1'b0;

   always #5 aclk = ~aclk;

   zluudg_psdu_deframer dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_octet_tdata  (sTdata),
      .s_octet_tvalid (sTvalid),
      .s_octet_tready (sTready),
      .s_octet_tlast  (sTlast),
      .m_psdu_tdata   (mTdata),
      .m_psdu_tvalid  (mTvalid),
      .m_psdu_tready  (mTready),
      .m_psdu_tlast   (mTlast),
      .m_psdu_tuser   (mTuser),
      .frame_count    (frameCount),
      .crc_err_count  (crcErrCount)
   );

   zluudg_crc16_kermit katCrc (
      .crc_in  (katIn),
      .octet   (katOctet),
      .crc_out (katOut)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Ready pattern: 0 = always ready, 1 = random 50%, 2 = never ready.
   initial begin
      mTready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         case (readyMode)
            1:       mTready = 1'($urandom_range(0, 1));
            2:       mTready = 1'b0;
            default: mTready = 1'b1;
         endcase
      end
   end

   // Records accepted beats and checks that a stalled beat does not change.
   initial begin
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            heldValid = 1'b0;
         end else begin
            if (heldValid) begin
               checkOutput("stallValid", {31'b0, mTvalid}, 32'd1);
               checkOutput("stallBeat", {21'b0, mTuser, mTlast, mTdata[7:0]}, {21'b0, heldBeat});
            end
            if (mTvalid && mTready) begin
               outQ.push_back({mTuser, mTlast, mTdata[7:0]});
               checkOutput("tdataUpper", {8'h00, mTdata[31:8]}, 32'd0);
            end
            heldValid = mTvalid && !mTready;
            heldBeat  = {mTuser, mTlast, mTdata[7:0]};
         end
      end
   end

   task automatic queueOctet(input logic [7:0] d, input logic last);
      stimQ.push_back({last, d});
   endtask

   task automatic expectBeat(input logic [1:0] user, input logic last, input logic [7:0] d);
      expQ.push_back({user, last, d});
   endtask

   task automatic sendOctet(input logic [8:0] item);
      int budget;
      sTvalid = 1'b1;
      sTdata  = {24'h000000, item[7:0]};
      sTlast  = item[8];
      budget  = 0;
      @(negedge aclk);
      while (!sTready && budget < 500) begin
         budget++;
         @(negedge aclk);
      end
      if (!sTready) checkOutput("inputTimeout", 32'd0, 32'd1);
      @(posedge aclk);
      #1;
      sTvalid = 1'b0;
      sTlast  = 1'b0;
   endtask

   task automatic applyStimulus();
      int n;
      foreach (stimQ[i]) sendOctet(stimQ[i]);
      stimQ.delete();
      n = 0;
      @(negedge aclk);
      while (mTvalid && n < 500) begin
         n++;
         @(negedge aclk);
      end
      checkOutput("drained", {31'b0, mTvalid}, 32'd0);
      @(posedge aclk);
      #1;
   endtask

   task automatic checkPacket(input string tag);
      int n;
      checkOutput({tag, "Count"}, outQ.size(), expQ.size());
      n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "Beat"}, {21'b0, outQ[i]}, {21'b0, expQ[i]});
      end
      outQ.delete();
      expQ.delete();
   endtask

   task automatic queueGoodFrame(input logic [7:0] fcsHi);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'hA7, 1'b0);
      queueOctet(8'h05, 1'b0);
      queueOctet(8'h02, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h56, 1'b0);
      queueOctet(8'h0B, 1'b0);
      queueOctet(fcsHi, 1'b1);
   endtask

   task automatic expectFrame(input logic [7:0] fcsHi, input logic [1:0] user);
      expectBeat(2'b00, 1'b0, 8'h02);
      expectBeat(2'b00, 1'b0, 8'h00);
      expectBeat(2'b00, 1'b0, 8'h56);
      expectBeat(2'b00, 1'b0, 8'h0B);
      expectBeat(user, 1'b1, fcsHi);
   endtask

   initial begin
      sTvalid  = 1'b0;
      sTdata   = 32'd0;
      sTlast   = 1'b0;
      katIn    = 16'h0000;
      katOctet = 8'h00;

      repeat (3) @(posedge aclk);
      #1;
      checkOutput("rstValid", {31'b0, mTvalid}, 32'd0);
      checkOutput("rstLast", {31'b0, mTlast}, 32'd0);
      checkOutput("rstUser", {30'b0, mTuser}, 32'd0);
      checkOutput("rstData", mTdata, 32'd0);
      checkOutput("rstFrameCount", {16'b0, frameCount}, 32'd0);
      checkOutput("rstCrcErrCount", {16'b0, crcErrCount}, 32'd0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      checkOutput("huntReady", {31'b0, sTready}, 32'd1);

      $display("[TB] CRC known-answer over \"123456789\"");
      for (int i = 0; i < 9; i++) begin
         katOctet = 8'(8'h31 + i);
         #1;
         katIn = katOut;
      end
      checkOutput("crcKat", {16'b0, katIn}, 32'h2189);

      $display("[TB] good frame at full rate");
      queueGoodFrame(8'h82);
      expectFrame(8'h82, 2'b01);
      applyStimulus();
      checkPacket("good");
      checkOutput("goodFrameCount", {16'b0, frameCount}, 32'd1);
      checkOutput("goodCrcErrCount", {16'b0, crcErrCount}, 32'd0);

      $display("[TB] bad FCS");
      queueGoodFrame(8'h83);
      expectFrame(8'h83, 2'b00);
      applyStimulus();
      checkPacket("badFcs");
      checkOutput("badFrameCount", {16'b0, frameCount}, 32'd2);
      checkOutput("badCrcErrCount", {16'b0, crcErrCount}, 32'd1);

      $display("[TB] single-zero preamble is ignored");
      queueOctet(8'h00, 1'b0);
      queueOctet(8'hA7, 1'b0);
      queueOctet(8'h05, 1'b0);
      queueOctet(8'h02, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h56, 1'b0);
      queueOctet(8'h0B, 1'b0);
      queueOctet(8'h82, 1'b1);
      applyStimulus();
      checkPacket("oneZero");
      checkOutput("oneZeroFrameCount", {16'b0, frameCount}, 32'd2);

      $display("[TB] length below minimum is dropped");
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'hA7, 1'b0);
      queueOctet(8'h02, 1'b0);
      queueOctet(8'hAA, 1'b0);
      queueOctet(8'hBB, 1'b1);
      applyStimulus();
      checkPacket("short");
      checkOutput("shortFrameCount", {16'b0, frameCount}, 32'd2);
      checkOutput("shortCrcErrCount", {16'b0, crcErrCount}, 32'd1);

      $display("[TB] truncated frame");
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'hA7, 1'b0);
      queueOctet(8'h05, 1'b0);
      queueOctet(8'h11, 1'b0);
      queueOctet(8'h22, 1'b0);
      queueOctet(8'h33, 1'b1);
      expectBeat(2'b00, 1'b0, 8'h11);
      expectBeat(2'b00, 1'b0, 8'h22);
      expectBeat(2'b10, 1'b1, 8'h33);
      applyStimulus();
      checkPacket("trunc");
      checkOutput("truncFrameCount", {16'b0, frameCount}, 32'd3);
      checkOutput("truncCrcErrCount", {16'b0, crcErrCount}, 32'd2);

      $display("[TB] random backpressure, back-to-back frames");
      readyMode = 1;
      queueGoodFrame(8'h82);
      queueGoodFrame(8'h83);
      expectFrame(8'h82, 2'b01);
      expectFrame(8'h83, 2'b00);
      applyStimulus();
      readyMode = 0;
      checkPacket("random");
      checkOutput("randomFrameCount", {16'b0, frameCount}, 32'd5);
      checkOutput("randomCrcErrCount", {16'b0, crcErrCount}, 32'd3);

      $display("[TB] reset in the middle of a payload");
      readyMode = 2;
      queueOctet(8'h00, 1'b0);
      queueOctet(8'h00, 1'b0);
      queueOctet(8'hA7, 1'b0);
      queueOctet(8'h05, 1'b0);
      queueOctet(8'h02, 1'b0);
      foreach (stimQ[i]) sendOctet(stimQ[i]);
      stimQ.delete();
      checkOutput("preResetValid", {31'b0, mTvalid}, 32'd1);
      checkOutput("preResetData", mTdata, 32'h02);
      #2;
      aresetn = 1'b0;
      #1;
      checkOutput("midResetValid", {31'b0, mTvalid}, 32'd0);
      checkOutput("midResetFrameCount", {16'b0, frameCount}, 32'd0);
      checkOutput("midResetCrcErrCount", {16'b0, crcErrCount}, 32'd0);
      @(posedge aclk);
      #1;
      aresetn   = 1'b1;
      readyMode = 0;
      @(posedge aclk);
      #1;
      checkPacket("resetDrop");

      $display("[TB] good frame after reset");
      queueGoodFrame(8'h82);
      expectFrame(8'h82, 2'b01);
      applyStimulus();
      checkPacket("afterReset");
      checkOutput("afterResetFrameCount", {16'b0, frameCount}, 32'd1);
      checkOutput("afterResetCrcErrCount", {16'b0, crcErrCount}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/zluudg_psdu_deframer.md
# zluudg_psdu_deframer

- Sits directly downstream of `zluudg_receiver` in the zluudgbee RX path.
- Consumes the demodulated octet stream, finds the IEEE 802.15.4 SHR (zero-byte preamble plus SFD 0xA7) and reads the PHR length.
- Emits the PSDU as one AXI-stream packet, with `tlast` on the final octet and FCS status in `tuser`.
- Keeps frame and CRC-error counters for readback.

## Interface
Parameters:
- `PREAMBLE_MIN`, default 2: minimum number of consecutive 0x00 octets required before the SFD.
- `SFD`, default 8'hA7: start-of-frame delimiter value.
- `MIN_LEN`, default 3: minimum accepted PHR length. Shorter frames are dropped silently.

Ports (one clock; reset is asynchronous and active-low):
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `s_octet_tdata` in 32: octet in [7:0]; [31:8] ignored.
- `s_octet_tvalid` in 1: input valid.
- `s_octet_tready` out 1: input ready.
- `s_octet_tlast` in 1: end of receiver burst.
- `m_psdu_tdata` out 32: PSDU octet in [7:0]; [31:8] = 0.
- `m_psdu_tvalid` out 1: output valid.
- `m_psdu_tready` in 1: output ready.
- `m_psdu_tlast` out 1: last octet of the frame.
- `m_psdu_tuser` out 2: {truncated, crc_ok}. Valid only on the `tlast` beat, 0 otherwise.
- `frame_count` out 16: count of frames emitted; wraps.
- `crc_err_count` out 16: count of frames emitted with crc_ok=0; wraps.

## Operation
- States: HUNT, PHR, PAYLOAD.
- HUNT:
  - `s_octet_tready`=1.
  - An accepted 0x00 increments `zcnt` (4 bit, saturates at 15).
  - An octet equal to SFD with `zcnt`≥PREAMBLE_MIN → PHR. Otherwise `zcnt`←0.
  - Input `tlast` clears `zcnt`.
- PHR:
  - `s_octet_tready`=1.
  - Length = octet[6:0]; bit 7 is ignored.
  - Length < MIN_LEN → HUNT, nothing emitted.
  - Otherwise: `remaining`←length, CRC←0 → PAYLOAD.
  - Input `tlast` on the PHR octet → HUNT.
- PAYLOAD:
  - Each accepted octet updates the CRC and is copied to the output register. `remaining` decrements.
  - When `remaining` reaches 1 on acceptance, the beat carries `tlast`=1 and tuser={0, crc_next==0}. State → HUNT.
- Input `tlast` in PAYLOAD before the final octet: the current octet is emitted with `tlast`=1 and tuser={1,0}. State → HUNT.
- CRC: CRC-16/KERMIT (reflected poly 0x8408, init 0x0000, LSB-first, no final xor). It runs over the PSDU including the 2-octet FCS; a residue of 0 means crc_ok.
- Counters: on each emitted `tlast` beat, `frame_count`++. `crc_err_count`++ when crc_ok=0 (truncated frames included).
- `zcnt` is cleared on leaving HUNT.

## Timing
- Reset values: state=HUNT, `zcnt`=0, `m_psdu_tvalid`=0, `m_psdu_tlast`=0, `m_psdu_tuser`=0, `m_psdu_tdata`=0, both counters=0, CRC=0.
- `s_octet_tready` by state:
  - HUNT and PHR: 1.
  - PAYLOAD: `!m_psdu_tvalid || m_psdu_tready`.
- Latency: a PAYLOAD octet accepted in cycle n is presented on the output in cycle n+1.
- Throughput: one octet per cycle under continuous ready.
- The output register holds data, `tlast` and `tuser` stable while `tvalid`=1 and `tready`=0.
- The CRC is updated with a single-cycle, 8-bit-parallel combinational step.
- Counters update in the cycle the `tlast` beat is loaded into the output register.
- HUNT may accept SHR octets of the next frame while the last beat of the previous frame is still stalled. PAYLOAD waits for the register to free.
- Reset asserted mid-frame: the packet is abandoned and `m_psdu_tvalid` drops immediately (asynchronous). No `tlast` is emitted.

## Structure
- Package `zluudg_bee_pkg`:
  - state enum.
  - `SFD_DEFAULT`, `CRC_POLY_REFL`=16'h8408, `MAX_PSDU`=127.
  - function `crc16_kermit_byte(crc, octet)`.
- Sub-module `zluudg_crc16_kermit`: combinational octet step, reused later by the TX path.

## Test plan
- Known-answer: ASCII "123456789" through `zluudg_crc16_kermit` → 0x2189.
- Good frame: octets 00 00 00 00 A7 05 02 00 56 0B 82 at full rate with `m_psdu_tready`=1 → out 02 00 56 0B 82, `tlast` on 0x82, tuser=2'b01, `frame_count`=1, `crc_err_count`=0.
- Bad FCS: same frame with last octet 0x83 → tuser=2'b00, `crc_err_count`=1.
- Hunt rules:
  - 00 A7 05 … (one zero) → nothing emitted.
  - 00 00 00 00 A7 02 … → length below MIN_LEN → dropped; no counter change.
- Truncation: input `tlast` on the third PSDU octet of a length-5 frame → 3 octets out, `tlast` on the third, tuser=2'b10.
- Backpressure/reset:
  - Random `m_psdu_tready` (50%) → identical output sequence, with no beat changing while stalled.
  - `aresetn` low mid-PAYLOAD → `tvalid`=0 and counters=0 at once. The next good frame passes cleanly.
